// File: rtl/fb_pkg.sv
// Shared types and sizes for the double-buffered LED frame store.
package fb_pkg;

  localparam int FB_ADDR_W = 8;
  localparam int FB_DATA_W = 16;
  localparam int FB_DEPTH  = 1 << FB_ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_CLEAR     = 2'd1,
    ST_SWAP_WAIT = 2'd2
  } fb_state_e;

endpackage

// File: rtl/fb_bank.sv
// One scan channel: two pixel buffers, one write port, one registered
// read port, each with its own buffer select.
module fb_bank
  import fb_pkg::*;
#(
  parameter int ADDR_W = FB_ADDR_W,
  parameter int DATA_W = FB_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic              wsel_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              rsel_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem0_q [DEPTH];
  logic [DATA_W-1:0] mem1_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i && !wsel_i) begin
      mem0_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (we_i && wsel_i) begin
      mem1_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rsel_i ? mem1_q[raddr_i] : mem0_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/frame_buffer_ctrl.sv
// Front/back frame store for the two-panel scan engine: host writes,
// tear-free swap at frame boundary, and back-buffer zero fill.
module frame_buffer_ctrl
  import fb_pkg::*;
#(
  parameter int ADDR_W = FB_ADDR_W,
  parameter int DATA_W = FB_DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wr_valid,
  output logic              o_wr_ready,
  input  logic              i_wr_chan,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_swap_req,
  input  logic              i_clear_req,
  output logic              o_swap_pending,
  output logic              o_swap_done,
  output logic              o_busy,
  output logic              o_front_sel,
  input  logic              i_frame_end,
  input  logic [ADDR_W-1:0] i_raddr_1,
  output logic [DATA_W-1:0] o_rdata_1,
  input  logic [ADDR_W-1:0] i_raddr_2,
  output logic [DATA_W-1:0] o_rdata_2
);

  localparam logic [ADDR_W:0] CLR_LAST = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [ADDR_W:0] CLR_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  fb_state_e state_q, state_d;

  logic            front_q, front_d;
  logic            swap_q, swap_d;
  logic            done_q, done_d;
  logic            live_q;
  logic [ADDR_W:0] clr_q, clr_d;

  logic              clr_active;
  logic              wr_fire;
  logic              we_1, we_2;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // live_q holds write-ready low until the first edge after reset release
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      front_q <= 1'b0;
      swap_q  <= 1'b0;
      done_q  <= 1'b0;
      live_q  <= 1'b0;
      clr_q   <= '0;
    end else begin
      front_q <= front_d;
      swap_q  <= swap_d;
      done_q  <= done_d;
      live_q  <= 1'b1;
      clr_q   <= clr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    front_d = front_q;
    swap_d  = swap_q;
    done_d  = 1'b0;
    clr_d   = clr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_clear_req) begin
          state_d = ST_CLEAR;
          clr_d   = '0;
          if (i_swap_req) begin
            swap_d = 1'b1;
          end
        end else if (i_swap_req) begin
          state_d = ST_SWAP_WAIT;
          swap_d  = 1'b1;
        end
      end
      ST_CLEAR: begin
        clr_d = clr_q + CLR_ONE;
        if (i_swap_req) begin
          swap_d = 1'b1;
        end
        if (clr_q == CLR_LAST) begin
          state_d = (swap_q || i_swap_req) ? ST_SWAP_WAIT : ST_IDLE;
        end
      end
      ST_SWAP_WAIT: begin
        if (i_frame_end) begin
          state_d = ST_IDLE;
          front_d = ~front_q;
          swap_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    o_busy         = (state_q == ST_CLEAR);
    o_wr_ready     = live_q && (state_q == ST_IDLE) && !swap_q;
    o_swap_pending = swap_q;
    o_swap_done    = done_q;
    o_front_sel    = front_q;
  end

  // Clear owns both write ports; the host is held off by o_wr_ready
  assign clr_active = (state_q == ST_CLEAR);
  assign wr_fire    = i_wr_valid && o_wr_ready;
  assign we_1       = clr_active || (wr_fire && !i_wr_chan);
  assign we_2       = clr_active || (wr_fire && i_wr_chan);
  assign waddr      = clr_active ? clr_q[ADDR_W-1:0] : i_wr_addr;
  assign wdata      = clr_active ? '0 : i_wr_data;

  fb_bank #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_bank_1 (
    .clk_i   (i_clk),
    .rst_ni  (i_rst_n),
    .we_i    (we_1),
    .wsel_i  (~front_q),
    .waddr_i (waddr),
    .wdata_i (wdata),
    .rsel_i  (front_q),
    .raddr_i (i_raddr_1),
    .rdata_o (o_rdata_1)
  );

  fb_bank #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_bank_2 (
    .clk_i   (i_clk),
    .rst_ni  (i_rst_n),
    .we_i    (we_2),
    .wsel_i  (~front_q),
    .waddr_i (waddr),
    .wdata_i (wdata),
    .rsel_i  (front_q),
    .raddr_i (i_raddr_2),
    .rdata_o (o_rdata_2)
  );

endmodule

// File: doc/frame_buffer_ctrl.md
Name: frame_buffer_ctrl

Overview:
- Double-buffered pixel store and access scheduler for the two-channel LED matrix scan engine.
- Host writes (from the ESP32 SPI bridge) always go to the back buffer. The scan engine reads the front buffer through two read ports.
- Host swap requests are deferred to the scan engine's frame boundary, so a displayed frame is never torn.
- A host clear request zero-fills the back buffer.

Parameters:
- ADDR_W, 8, pixel address width per channel (DEPTH = 2**ADDR_W = 256).
- DATA_W, 16, pixel word width (matches the scan engine's read data).

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  reset, asynchronous assert, active-low.
- i_wr_valid  in  1  host write request.
- o_wr_ready  out  1  write accepted when valid && ready.
- i_wr_chan  in  1  target channel (0 = panel 1, 1 = panel 2).
- i_wr_addr  in  ADDR_W  back-buffer pixel address.
- i_wr_data  in  DATA_W  pixel word.
- i_swap_req  in  1  single-cycle pulse: present the back buffer at the next frame boundary.
- i_clear_req  in  1  single-cycle pulse: zero-fill the back buffer, both channels.
- o_swap_pending  out  1  swap requested, not yet applied.
- o_swap_done  out  1  single-cycle pulse when the swap is applied.
- o_busy  out  1  clear in progress.
- o_front_sel  out  1  index of the buffer currently displayed.
- i_frame_end  in  1  pulse from the scan engine after its last PWM plane is latched.
- i_raddr_1  in  ADDR_W  scan read address, channel 0.
- o_rdata_1  out  DATA_W  front-buffer data, channel 0.
- i_raddr_2  in  ADDR_W  scan read address, channel 1.
- o_rdata_2  out  DATA_W  front-buffer data, channel 1.

Behaviour:
- Reset values (asynchronous, i_rst_n = 0):
  - state = IDLE, front_sel = 0, swap_latched = 0, clr_cnt = 0.
  - All outputs 0, including o_wr_ready and rdata.
  - RAM contents are not reset and are undefined after power-up.
- Read path:
  - o_rdata_n = buffer[front_sel][i_raddr_n], registered, latency 1 cycle.
  - Both read ports are independent, and reads are never stalled.
- Front/back switch timing:
  - front_sel changes only on the edge where a swap is applied.
  - A read address presented in that same cycle returns old-front data. The next address returns new-front data.
- Write path:
  - o_wr_ready = 1 only in state IDLE with swap_latched = 0.
  - On accept, buffer[~front_sel] of channel i_wr_chan is written at the next edge.
  - No write ever reaches the front buffer.
- State machine (3 states: IDLE, CLEAR, SWAP_WAIT):
  - IDLE + i_clear_req -> CLEAR. clr_cnt = 0. Any i_swap_req in the same cycle sets swap_latched.
  - IDLE + i_swap_req (no clear) -> SWAP_WAIT. swap_latched = 1.
  - CLEAR: each cycle writes 0 to address clr_cnt of the back buffer in both channels, then clr_cnt++. o_busy = 1.
  - CLEAR at clr_cnt = DEPTH-1: the last write occurs. Next state is SWAP_WAIT if swap_latched, else IDLE. Total 256 cycles.
  - CLEAR + i_swap_req: sets swap_latched. CLEAR + i_clear_req: ignored.
  - SWAP_WAIT: o_swap_pending = 1.
    - On i_frame_end: front_sel toggles, swap_latched = 0, o_swap_done pulses on the next cycle, next state IDLE.
    - i_swap_req and i_clear_req are ignored in this state.
  - i_frame_end is ignored outside SWAP_WAIT.
  - An i_frame_end coincident with the cycle that enters SWAP_WAIT is not counted; the swap waits for the following frame_end.
- o_swap_pending = swap_latched (also high during a CLEAR with a latched swap).
- clr_cnt is ADDR_W+1 bits wide and cannot wrap in normal operation.
- Reset mid-clear or mid-wait abandons the operation. front_sel returns to 0, and the partial clear is left in RAM.
- No i_frame_end timeout: a pending swap waits indefinitely and the host polls o_swap_pending.

Decomposition:
- Shared package fb_pkg:
  - state encodings ST_IDLE/ST_CLEAR/ST_SWAP_WAIT.
  - FB_ADDR_W = 8, FB_DATA_W = 16, FB_DEPTH = 256.
- Sub-module fb_bank:
  - One channel: two DEPTH x DATA_W buffers (one 4 kbit EBR each), one write port with buffer select, one registered read port with buffer select.
  - Instantiated twice by frame_buffer_ctrl, which holds the FSM, clr_cnt, front_sel and the handshake.

Test Plan:
- Reset, then read all addresses on both ports -> o_front_sel = 0, o_wr_ready = 1 one cycle after reset release, no X on control outputs.
- Write chan0 addr 5 = 0x1234 and chan1 addr 5 = 0xABCD, then read addr 5 -> old front data unchanged. Swap, then frame_end 10 cycles later -> o_swap_done one cycle after the frame_end, o_rdata_1 = 0x1234, o_rdata_2 = 0xABCD.
- i_swap_req with no frame_end for 1000 cycles -> o_swap_pending = 1 and o_wr_ready = 0 throughout, front_sel unchanged. frame_end coincident with the swap_req cycle is not counted.
- Fill back buffer with 0xFFFF, then i_clear_req -> o_busy high for exactly 256 cycles, write held off. After swap, every address reads 0 on both ports.
- i_clear_req and i_swap_req in the same cycle -> 256-cycle clear, then SWAP_WAIT. frame_end during the clear has no effect; the next frame_end applies the swap.
- Assert i_rst_n = 0 mid-clear (clr_cnt = 100) and during SWAP_WAIT after a prior swap -> immediate IDLE, front_sel = 0, all outputs 0.
